// File: rtl/xm_bus_pkg.sv
// ---------------------------------------------------------------------------
// xm_bus_pkg : shared Wishbone bus widths and arbiter state type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package xm_bus_pkg;

  localparam int BUS_AW      = 15;
  localparam int BUS_DW      = 16;
  localparam int BUS_SW      = BUS_DW / 8;
  localparam int BUS_TIMEOUT = 16;

  // Encoding matches the one-hot grant vector so gnt can be taken straight from the state.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_arb_timer.sv
// ---------------------------------------------------------------------------
// wb_arb_timer : counts unacknowledged strobe cycles of the bus owner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic clr_i,
  input  logic ack_i,
  input  logic stall_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Fires on the TIMEOUT-th stall cycle itself, not the one after.
  assign expire_o = stall_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || ack_i || expire_o) begin
      cnt_d = '0;
    end else if (stall_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter2.sv
// ---------------------------------------------------------------------------
// wb_arbiter2 : two-master round-robin Wishbone arbiter, whole-cycle grants
// Optional slave timeout abort: define WB_ARB_TIMEOUT_EN.      Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_arbiter2
  import xm_bus_pkg::*;
#(
  parameter int AW      = BUS_AW,
  parameter int DW      = BUS_DW,
  parameter int SW      = BUS_SW,
  parameter int TIMEOUT = BUS_TIMEOUT
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [SW-1:0] s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [DW-1:0] m_dat_o,
  output logic [1:0]    gnt_o
);

  arb_state_t    state_q;
  arb_state_t    state_d;
  logic          last_q;
  logic          last_d;
  logic          expire;
  logic          own_cyc;
  logic          own_stb;
  logic          own_we;
  logic [SW-1:0] own_sel;
  logic [AW-1:0] own_adr;
  logic [DW-1:0] own_dat;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    case (state_q)
      OWN0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        own_we  = m0_we_i;
        own_sel = m0_sel_i;
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
      end
      OWN1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        own_we  = m1_we_i;
        own_sel = m1_sel_i;
        own_adr = m1_adr_i;
        own_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic stall;

  assign stall = own_stb && !s_ack_i;

  wb_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .clr_i    (state_d != state_q),
    .ack_i    (s_ack_i),
    .stall_i  (stall),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // last_q holds the index of the most recent owner; ties go to the other one.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_d = OWN0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (expire || !m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = (m1_cyc_i && !expire) ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (expire || !m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = (m0_cyc_i && !expire) ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign s_cyc_o  = own_cyc && !expire;
  assign s_stb_o  = own_stb && !expire;
  assign s_we_o   = own_we;
  assign s_sel_o  = own_sel;
  assign s_adr_o  = own_adr;
  assign s_dat_o  = own_dat;
  assign m_dat_o  = s_dat_i;
  assign m0_ack_o = (state_q == OWN0) && s_ack_i;
  assign m1_ack_o = (state_q == OWN1) && s_ack_i;
  assign m0_err_o = (state_q == OWN0) && expire;
  assign m1_err_o = (state_q == OWN1) && expire;
  assign gnt_o    = state_q;

endmodule

`default_nettype wire
